seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Parametrised multiplexed seven-segment display controller: time-division scans `DIGITS` common-enable digits, decodes a per-digit hex nibble to segment patterns, and applies a dead-time guard between digits to suppress ghosting. Display data is double-buffered: a `load` strobe fills a pending buffer that takes effect only at a frame boundary, so a frame never shows mixed old and new data. Sits between the counter/datapath blocks and the board's digit-select and segment pins.

## Interface
- `DIGITS`, 8: number of digits scanned; legal 2..16.
- `DIV`, 4096: clocks per digit slot; legal ≥ 2.
- `GUARD`, 16: blanking clocks at start of each slot; legal 0..DIV-1.
- `SELW`, derived = max(1, $clog2(DIGITS)): width of `sel`; not to be overridden.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  single-cycle strobe; captures `data`, `dp`, `blank` into pending buffer.
- `data`  in  4*DIGITS  hex nibble per digit; digit i = data[4i+3:4i]; digit 0 least significant.
- `dp`  in  DIGITS  decimal point per digit.
- `blank`  in  DIGITS  1 = digit i dark for whole slot.
- `sel`  out  SELW  index of digit currently scanned.
- `ds`  out  DIGITS  one-hot digit enable, active-high.
- `seg`  out  8  segments, active-high; bit0..6 = a..g, bit7 = dp.
- `frame`  out  1  one-clock pulse on the edge `sel` wraps to 0.
- `pending`  out  1  pending buffer holds data not yet applied.

## Operation
- Reset (async, `rst_n`=0): prescaler 0, `sel`=0, `ds`=0, `seg`=0, `frame`=0, `pending`=0, active and pending buffers all zero (`data`=0, `dp`=0, `blank`=0).
- Prescaler `cnt` counts 0..DIV-1 every clock; at DIV-1 it returns to 0 and `sel` advances; `sel` wraps DIGITS-1 → 0 (non-power-of-two DIGITS never reach unused codes).
- `ds`: all zero while `cnt` < GUARD; otherwise one-hot of `sel`, unless active `blank[sel]`=1 (then all zero).
- `seg`: loaded on the slot-start edge with glyph of active `data[sel]` plus active `dp[sel]` in bit7; held for the slot. Hex decode standard: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,b=7C,C=39,d=5E,E=79,F=71.
- Load: `load`=1 copies inputs into pending buffer, sets `pending`. Repeated loads before a boundary overwrite; last wins.
- Frame boundary (edge where `sel` wraps to 0): if `pending`, active ← pending and `pending` clears; the digit-0 glyph on that same edge uses the new active data. `frame` pulses on that edge.
- `load` on the boundary edge: previously pending data (if any) becomes active; the new load goes into pending, `pending` stays 1, applied at next boundary.
- Out-of-range parameters: compile-time error.

## Timing
- All outputs registered; `sel`, `ds`, `seg`, `frame` change on the same edge.
- Slot = DIV clocks; frame = DIGITS*DIV clocks; `ds` high DIV-GUARD clocks per slot.
- First slot after reset release: `sel`=0, `cnt` starts 0; first advance after DIV clocks. Initial active buffer is zero, so digit glyph 0x3F appears from the first lit cycle (cnt = GUARD).
- Load-to-display latency: up to one frame + 1 clock; `pending` visible the clock after `load`.
- Reset mid-slot or mid-load: everything returns to reset values immediately; pending data discarded.

## Configuration
- `SEG_SCAN_CTRL_LZB_EN` defined: leading-zero blanking. Active digits from DIGITS-1 down to the highest nonzero nibble that have value 0 are suppressed (`seg` bits 0..6 forced 0; bit7 still follows `dp`). Digit 0 never suppressed. Evaluated from the active buffer.
- Not defined: every digit shows its glyph; no extra logic.

## Test plan
- Params DIGITS=4, DIV=4, GUARD=1, no load: after reset `sel` cycles 0,1,2,3,0 every 4 clocks; `ds` = 0000 for 1 clock then 0001/0010/0100/1000; `seg`=0x3F; `frame` pulses every 16 clocks.
- Load `data`=16'h4A21, dp=4'b0010 mid-frame: `pending`=1 next clock; display unchanged until wrap; then seg sequence 0x06, 0xDB, 0x77, 0x66; `pending`=0.
- Two loads in one frame (0x1111 then 0x2222) then a load exactly on the wrap edge (0x3333): frame N+1 shows 2222, `pending` stays 1, frame N+2 shows 3333.
- blank=4'b0100: `ds` stays 0000 for whole slot of `sel`=2; other digits normal.
- Assert `rst_n`=0 during slot 2 with pending data: `ds`=0, `seg`=0, `sel`=0, `pending`=0 asynchronously; after release display shows 0000.
- With `SEG_SCAN_CTRL_LZB_EN`, data=16'h0050: digits 3 and 2 seg=0x00, digit 1 0x6D, digit 0 0x3F; data=0 shows only digit 0 = 0x3F.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Signal bundle for seg_scan_ctrl: display data and load strobe from the datapath,
// digit-select and segment drive toward the board pins.
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 8
);
  localparam int SELW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     blank;
  logic [SELW-1:0]       sel;
  logic [DIGITS-1:0]     ds;
  logic [7:0]            seg;
  logic                  frame;
  logic                  pending;

  modport master (
    output load, data, dp, blank,
    input  sel, ds, seg, frame, pending
  );

  modport slave (
    input  load, data, dp, blank,
    output sel, ds, seg, frame, pending
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with per-slot dead time and frame-aligned double buffering.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_CTRL_LZB_EN.
module seg_scan_ctrl #(
  parameter int DIGITS = 8,
  parameter int DIV    = 4096,
  parameter int GUARD  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam int SELW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNTW = $clog2(DIV);

  if (DIGITS < 2 || DIGITS > 16) begin : g_bad_digits
    $error("seg_scan_ctrl: DIGITS must be in 2..16");
  end
  if (DIV < 2) begin : g_bad_div
    $error("seg_scan_ctrl: DIV must be at least 2");
  end
  if (GUARD < 0 || GUARD > DIV - 1) begin : g_bad_guard
    $error("seg_scan_ctrl: GUARD must be in 0..DIV-1");
  end

  typedef logic [DIGITS-1:0][3:0] nib_t;

  logic [CNTW-1:0]   cnt_reg, cnt_next;
  logic [SELW-1:0]   sel_reg, sel_next;
  logic [DIGITS-1:0] ds_reg, ds_next;
  logic [7:0]        seg_reg, seg_next;
  logic              frame_reg;
  logic              pending_reg, pending_next;
  logic              slot_end, wrap;

  nib_t              act_data_reg, act_data_next, pnd_data_reg;
  logic [DIGITS-1:0] act_dp_reg, act_dp_next, pnd_dp_reg;
  logic [DIGITS-1:0] act_blank_reg, act_blank_next, pnd_blank_reg;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h07;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h6F;
      4'hA:    glyph = 7'h77;
      4'hB:    glyph = 7'h7C;
      4'hC:    glyph = 7'h39;
      4'hD:    glyph = 7'h5E;
      4'hE:    glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  always_comb begin : scan_next
    slot_end = (cnt_reg == CNTW'(DIV - 1));
    wrap     = slot_end && (sel_reg == SELW'(DIGITS - 1));
    cnt_next = slot_end ? '0 : cnt_reg + 1'b1;
    sel_next = sel_reg;
    if (slot_end) begin
      sel_next = wrap ? '0 : sel_reg + 1'b1;
    end

    // The swap happens on the wrap edge itself so digit 0 of the new frame already sees it.
    act_data_next  = act_data_reg;
    act_dp_next    = act_dp_reg;
    act_blank_next = act_blank_reg;
    if (wrap && pending_reg) begin
      act_data_next  = pnd_data_reg;
      act_dp_next    = pnd_dp_reg;
      act_blank_next = pnd_blank_reg;
    end

    pending_next = pending_reg;
    if (wrap) begin
      pending_next = 1'b0;
    end
    if (bus.load) begin
      pending_next = 1'b1;
    end
  end

`ifdef SEG_SCAN_CTRL_LZB_EN
  // hi_zero[i]: nibbles i..DIGITS-1 of the active buffer are all zero.
  logic [DIGITS:0] hi_zero;
  assign hi_zero[DIGITS] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
    assign hi_zero[gi] = (act_data_next[gi] == 4'h0) && hi_zero[gi+1];
  end
`endif

  always_comb begin : out_next
    ds_next = '0;
    if ((cnt_next >= CNTW'(GUARD)) && !act_blank_next[sel_next]) begin
      ds_next[sel_next] = 1'b1;
    end
    seg_next = {act_dp_next[sel_next], glyph(act_data_next[sel_next])};
`ifdef SEG_SCAN_CTRL_LZB_EN
    if ((sel_next != '0) && hi_zero[sel_next]) begin
      seg_next[6:0] = 7'h00;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      sel_reg       <= '0;
      ds_reg        <= '0;
      seg_reg       <= '0;
      frame_reg     <= 1'b0;
      pending_reg   <= 1'b0;
      act_data_reg  <= '0;
      act_dp_reg    <= '0;
      act_blank_reg <= '0;
      pnd_data_reg  <= '0;
      pnd_dp_reg    <= '0;
      pnd_blank_reg <= '0;
    end else begin
      cnt_reg       <= cnt_next;
      sel_reg       <= sel_next;
      ds_reg        <= ds_next;
      seg_reg       <= seg_next;
      frame_reg     <= wrap;
      pending_reg   <= pending_next;
      act_data_reg  <= act_data_next;
      act_dp_reg    <= act_dp_next;
      act_blank_reg <= act_blank_next;
      if (bus.load) begin
        pnd_data_reg  <= bus.data;
        pnd_dp_reg    <= bus.dp;
        pnd_blank_reg <= bus.blank;
      end
    end
  end

  assign bus.sel     = sel_reg;
  assign bus.ds      = ds_reg;
  assign bus.seg     = seg_reg;
  assign bus.frame   = frame_reg;
  assign bus.pending = pending_reg;
endmodule
